// File: rtl/ps2_emu_tx_multi.sv
// Multi-channel PS/2 device-side transmitter: shared clock divider, per-channel byte FIFO,
// frame serialiser with host-inhibit abort/retransmit and sticky FIFO overflow reporting.
module ps2_emu_tx_multi #(
    parameter int CHANNELS  = 2,
    parameter int FIFO_BITS = 3,
    parameter int PS2DIV    = 100
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic [8*CHANNELS-1:0] wr_data,
    input  logic [CHANNELS-1:0]   wr_strobe,
    input  logic [CHANNELS-1:0]   ps2_clk_in,
    input  logic [CHANNELS-1:0]   overflow_clr,
    output logic [CHANNELS-1:0]   ps2_clk_out,
    output logic [CHANNELS-1:0]   ps2_data_out,
    output logic [CHANNELS-1:0]   fifo_full,
    output logic [CHANNELS-1:0]   fifo_overflow,
    output logic [CHANNELS-1:0]   busy
);

    localparam int unsigned            DEPTH    = 1 << FIFO_BITS;
    localparam int                     DIV_W    = $clog2(PS2DIV);
    localparam logic [DIV_W-1:0]       DIV_MAX  = DIV_W'(PS2DIV - 1);
    localparam logic [FIFO_BITS:0]     CNT_FULL = (FIFO_BITS + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } state_t;

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_clk_ps2;
    logic             w_tick;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
            r_clk_ps2 <= 1'b0;
        end else if (r_div_cnt == DIV_MAX) begin
            r_div_cnt <= '0;
            r_clk_ps2 <= ~r_clk_ps2;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign w_tick = (r_div_cnt == DIV_MAX) && !r_clk_ps2;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [7:0]           r_mem [DEPTH];
        logic [FIFO_BITS-1:0] r_wptr;
        logic [FIFO_BITS-1:0] r_rptr;
        logic [FIFO_BITS:0]   r_count;
        logic                 r_ovf;
        state_t               r_state;
        state_t               w_state_nx;
        logic [7:0]           r_shift;
        logic [7:0]           w_shift_nx;
        logic                 r_par;
        logic                 w_par_nx;
        logic [2:0]           r_bit;
        logic [2:0]           w_bit_nx;
        logic                 r_data;
        logic                 w_data_nx;
        logic                 r_sync1;
        logic                 r_sync2;
        logic                 r_inh;
        logic                 w_clk_out;
        logic                 w_pop;
        logic                 w_push;

        assign w_clk_out = r_clk_ps2 | (r_state == S_IDLE);

        // Inhibit is only meaningful while our clock is released; the value sampled in the
        // high phase is held through the low phase so the tick at its end can act on it.
        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                r_sync1 <= 1'b1;
                r_sync2 <= 1'b1;
                r_inh   <= 1'b0;
            end else begin
                r_sync1 <= ps2_clk_in[g];
                r_sync2 <= r_sync1;
                if (w_clk_out) begin
                    r_inh <= !r_sync2;
                end
            end
        end

        assign w_push = wr_strobe[g] && ((r_count != CNT_FULL) || w_pop);

        always_ff @(posedge clk_sys) begin
            if (w_push) begin
                r_mem[r_wptr] <= wr_data[8*g +: 8];
            end
        end

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + 1'b1;
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - 1'b1;
                end
                if (wr_strobe[g] && !w_push) begin
                    r_ovf <= 1'b1;
                end else if (overflow_clr[g]) begin
                    r_ovf <= 1'b0;
                end
            end
        end

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                r_state <= S_IDLE;
                r_shift <= '0;
                r_par   <= 1'b1;
                r_bit   <= '0;
                r_data  <= 1'b1;
            end else begin
                r_state <= w_state_nx;
                r_shift <= w_shift_nx;
                r_par   <= w_par_nx;
                r_bit   <= w_bit_nx;
                r_data  <= w_data_nx;
            end
        end

        always_comb begin
            w_state_nx = r_state;
            w_shift_nx = r_shift;
            w_par_nx   = r_par;
            w_bit_nx   = r_bit;
            w_data_nx  = r_data;
            w_pop      = 1'b0;
            if (w_tick) begin
                // The head stays in the FIFO until DONE, so an abort simply retries it later.
                if (r_inh && (r_state != S_IDLE) && (r_state != S_DONE)) begin
                    w_state_nx = S_IDLE;
                    w_data_nx  = 1'b1;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            if ((r_count != '0) && !r_inh) begin
                                w_shift_nx = r_mem[r_rptr];
                                w_par_nx   = 1'b1;
                                w_bit_nx   = '0;
                                w_data_nx  = 1'b0;
                                w_state_nx = S_DATA;
                            end
                        end
                        S_DATA: begin
                            w_data_nx  = r_shift[0];
                            w_shift_nx = {1'b0, r_shift[7:1]};
                            w_par_nx   = r_par ^ r_shift[0];
                            w_bit_nx   = r_bit + 3'd1;
                            if (r_bit == 3'd7) begin
                                w_state_nx = S_PARITY;
                            end
                        end
                        S_PARITY: begin
                            w_data_nx  = r_par;
                            w_state_nx = S_STOP;
                        end
                        S_STOP: begin
                            w_data_nx  = 1'b1;
                            w_state_nx = S_DONE;
                        end
                        S_DONE: begin
                            w_pop      = 1'b1;
                            w_data_nx  = 1'b1;
                            w_state_nx = S_IDLE;
                        end
                        default: begin
                            w_data_nx  = 1'b1;
                            w_state_nx = S_IDLE;
                        end
                    endcase
                end
            end
        end

        assign ps2_clk_out[g]   = w_clk_out;
        assign ps2_data_out[g]  = r_data;
        assign fifo_full[g]     = (r_count == CNT_FULL);
        assign fifo_overflow[g] = r_ovf;
        assign busy[g]          = (r_state != S_IDLE) || (r_count != '0);
    end

endmodule

// File: tb/tb_ps2_emu_tx_multi.sv
// Bench for ps2_emu_tx_multi: host-side frame monitor per channel, expected bytes queued at
// write time and popped as complete frames are received.
module tb_ps2_emu_tx_multi;

    localparam int CH  = 2;
    localparam int FB  = 2;
    localparam int DIV = 2;

    logic            clk_sys = 1'b0;
    logic            reset_n;
    logic [8*CH-1:0] wr_data;
    logic [CH-1:0]   wr_strobe;
    logic [CH-1:0]   ps2_clk_in;
    logic [CH-1:0]   overflow_clr;
    logic [CH-1:0]   ps2_clk_out;
    logic [CH-1:0]   ps2_data_out;
    logic [CH-1:0]   fifo_full;
    logic [CH-1:0]   fifo_overflow;
    logic [CH-1:0]   busy;

    ps2_emu_tx_multi #(
        .CHANNELS (CH),
        .FIFO_BITS(FB),
        .PS2DIV   (DIV)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .wr_data      (wr_data),
        .wr_strobe    (wr_strobe),
        .ps2_clk_in   (ps2_clk_in),
        .overflow_clr (overflow_clr),
        .ps2_clk_out  (ps2_clk_out),
        .ps2_data_out (ps2_data_out),
        .fifo_full    (fifo_full),
        .fifo_overflow(fifo_overflow),
        .busy         (busy)
    );

    always #5 clk_sys = ~clk_sys;

    int          errors;
    int          checks;
    int          frames [CH];
    int          falls  [CH];
    int          aborts [CH];
    int          nbits  [CH];
    int          hi_cnt [CH];
    logic [10:0] frm      [CH];
    logic [10:0] last_frm [CH];
    logic        prev_clk [CH];
    logic [7:0]  q0 [$];
    logic [7:0]  q1 [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_sys);
        #1;
    endtask

    task automatic check_frame(input int c);
        logic [10:0] f;
        logic [7:0]  eb;
        int          sz;
        f  = frm[c];
        sz = (c == 0) ? q0.size() : q1.size();
        chk("frame_expected", 32'(sz != 0), 1);
        if (sz != 0) begin
            eb = (c == 0) ? q0.pop_front() : q1.pop_front();
            chk("frame_byte", 32'(f[8:1]), 32'(eb));
        end
        chk("frame_start", 32'(f[0]), 0);
        chk("frame_parity", 32'(f[9]), 32'(~^f[8:1]));
        chk("frame_stop", 32'(f[10]), 1);
    endtask

    // Host model: sample data on each falling edge of the device clock.
    task automatic monitor();
        forever begin
            @(negedge clk_sys);
            for (int c = 0; c < CH; c++) begin
                if (prev_clk[c] && !ps2_clk_out[c]) begin
                    falls[c]++;
                    hi_cnt[c] = 0;
                    frm[c][nbits[c]] = ps2_data_out[c];
                    nbits[c]++;
                    if (nbits[c] == 11) begin
                        last_frm[c] = frm[c];
                        nbits[c]    = 0;
                        check_frame(c);
                        frames[c]++;
                    end
                end else if (ps2_clk_out[c]) begin
                    hi_cnt[c]++;
                    if (hi_cnt[c] > 2*DIV && nbits[c] != 0) begin
                        aborts[c]++;
                        nbits[c] = 0;
                    end
                end else begin
                    hi_cnt[c] = 0;
                end
                prev_clk[c] = ps2_clk_out[c];
            end
        end
    endtask

    task automatic write(input int c, input logic [7:0] b);
        wr_data[8*c +: 8] = b;
        wr_strobe[c]      = 1'b1;
        step();
        wr_strobe[c]      = 1'b0;
    endtask

    task automatic wait_frames(input int c, input int target, input int budget, input string tag);
        int k = 0;
        while (frames[c] < target && k < budget) begin
            step();
            k++;
        end
        chk(tag, 32'(frames[c]), 32'(target));
    endtask

    task automatic wait_idle(input int c, input int budget, input string tag);
        int k = 0;
        while (busy[c] && k < budget) begin
            step();
            k++;
        end
        chk(tag, 32'(busy[c]), 0);
    endtask

    task automatic wait_bits(input int c, input int n, input int budget, input string tag);
        int k = 0;
        while (nbits[c] < n && k < budget) begin
            step();
            k++;
        end
        chk(tag, 32'(nbits[c] >= n), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, f1, fl0, fl1, ab0, k;
        errors = 0;
        checks = 0;
        for (int c = 0; c < CH; c++) begin
            frames[c]   = 0;
            falls[c]    = 0;
            aborts[c]   = 0;
            nbits[c]    = 0;
            hi_cnt[c]   = 0;
            frm[c]      = '0;
            last_frm[c] = '0;
            prev_clk[c] = 1'b1;
        end
        reset_n      = 1'b0;
        wr_data      = '0;
        wr_strobe    = '0;
        ps2_clk_in   = '1;
        overflow_clr = '0;
        fork
            monitor();
        join_none
        repeat (3) step();
        chk("rst_clk", 32'(ps2_clk_out), 32'h3);
        chk("rst_data", 32'(ps2_data_out), 32'h3);
        chk("rst_full", 32'(fifo_full), 0);
        chk("rst_ovf", 32'(fifo_overflow), 0);
        chk("rst_busy", 32'(busy), 0);
        reset_n = 1'b1;
        repeat (4) step();

        // 1: single byte on ch0
        q0.push_back(8'h1C);
        f0  = frames[0];
        fl0 = falls[0];
        write(0, 8'h1C);
        k = 0;
        while (falls[0] == fl0 && k < 3*DIV + 2) begin
            step();
            k++;
        end
        chk("t1_latency", 32'(falls[0] != fl0), 1);
        wait_frames(0, f0 + 1, 200, "t1_frame");
        chk("t1_bits", 32'(last_frm[0]), 32'h438);
        wait_idle(0, 20, "t1_busy");
        chk("t1_pulses", 32'(falls[0] - fl0), 11);
        chk("t1_full", 32'(fifo_full[0]), 0);

        // 2: fill ch1 while inhibited, overflow on the fifth byte
        ps2_clk_in[1] = 1'b0;
        repeat (8) step();
        f1  = frames[1];
        fl1 = falls[1];
        for (int i = 0; i < 5; i++) begin
            wr_data[15:8] = 8'(8'h31 + i);
            wr_strobe[1]  = 1'b1;
            if (i < 4) q1.push_back(8'(8'h31 + i));
            step();
            if (i == 2) chk("t2_notfull", 32'(fifo_full[1]), 0);
            if (i == 3) chk("t2_full", 32'(fifo_full[1]), 1);
            if (i == 3) chk("t2_noovf", 32'(fifo_overflow[1]), 0);
            if (i == 4) chk("t2_ovf", 32'(fifo_overflow[1]), 1);
        end
        wr_strobe[1] = 1'b0;
        repeat (10) step();
        chk("t2_hold", 32'({ps2_clk_out[1], busy[1]}), 32'h3);
        chk("t2_nopulse", 32'(falls[1] - fl1), 0);
        ps2_clk_in[1] = 1'b1;
        wait_frames(1, f1 + 4, 800, "t2_frames");
        chk("t2_sticky", 32'(fifo_overflow[1]), 1);
        overflow_clr[1] = 1'b1;
        step();
        overflow_clr[1] = 1'b0;
        chk("t2_clr", 32'(fifo_overflow[1]), 0);
        wait_idle(1, 40, "t2_busy");

        // 3: inhibit mid-frame, retransmit, then the following byte
        q0.push_back(8'hA5);
        q0.push_back(8'h3C);
        f0  = frames[0];
        ab0 = aborts[0];
        write(0, 8'hA5);
        write(0, 8'h3C);
        wait_bits(0, 5, 100, "t3_reach_bit4");
        ps2_clk_in[0] = 1'b0;
        repeat (8*DIV) step();
        fl0 = falls[0];
        repeat (8*DIV) step();
        chk("t3_released", 32'({ps2_clk_out[0], ps2_data_out[0]}), 32'h3);
        chk("t3_nopulse", 32'(falls[0] - fl0), 0);
        chk("t3_nopop", 32'(busy[0]), 1);
        chk("t3_abort", 32'(aborts[0] - ab0), 1);
        chk("t3_noframe", 32'(frames[0]), 32'(f0));
        ps2_clk_in[0] = 1'b1;
        wait_frames(0, f0 + 1, 400, "t3_retx");
        chk("t3_retx_bits", 32'(last_frm[0]), 32'h74A);
        wait_frames(0, f0 + 2, 400, "t3_next");
        chk("t3_next_bits", 32'(last_frm[0]), 32'h678);
        wait_idle(0, 40, "t3_busy");

        // 4: concurrent frames on both channels
        q0.push_back(8'h12);
        q1.push_back(8'hFF);
        f0 = frames[0];
        f1 = frames[1];
        wr_data   = {8'hFF, 8'h12};
        wr_strobe = 2'b11;
        step();
        wr_strobe = 2'b00;
        wait_frames(0, f0 + 1, 200, "t4_ch0");
        wait_frames(1, f1 + 1, 200, "t4_ch1");
        chk("t4_ch0_bits", 32'(last_frm[0]), 32'h624);
        chk("t4_ch1_bits", 32'(last_frm[1]), 32'h7FE);
        wait_idle(0, 40, "t4_busy0");
        wait_idle(1, 40, "t4_busy1");

        // 5: write coincident with the DONE pop of a full FIFO
        ps2_clk_in[0] = 1'b0;
        repeat (8) step();
        f0 = frames[0];
        for (int i = 0; i < 4; i++) begin
            q0.push_back(8'(8'h51 + i));
            write(0, 8'(8'h51 + i));
        end
        chk("t5_full", 32'(fifo_full[0]), 1);
        q0.push_back(8'h55);
        ps2_clk_in[0] = 1'b1;
        wait_frames(0, f0 + 1, 200, "t5_first");
        repeat (DIV - 1) step();
        chk("t5_full_before", 32'(fifo_full[0]), 1);
        wr_data[7:0] = 8'h55;
        wr_strobe[0] = 1'b1;
        step();
        wr_strobe[0] = 1'b0;
        chk("t5_full_after", 32'(fifo_full[0]), 1);
        chk("t5_noovf", 32'(fifo_overflow[0]), 0);
        wait_frames(0, f0 + 5, 1000, "t5_all");
        wait_idle(0, 40, "t5_busy");

        // 6: asynchronous reset mid-frame
        q0.push_back(8'h66);
        write(0, 8'h66);
        wait_bits(0, 3, 100, "t6_midframe");
        reset_n = 1'b0;
        #1;
        chk("t6_clk", 32'(ps2_clk_out), 32'h3);
        chk("t6_data", 32'(ps2_data_out), 32'h3);
        chk("t6_full", 32'(fifo_full), 0);
        chk("t6_ovf", 32'(fifo_overflow), 0);
        chk("t6_busy", 32'(busy), 0);
        void'(q0.pop_front());
        repeat (3) step();
        reset_n = 1'b1;
        fl0 = falls[0];
        fl1 = falls[1];
        repeat (40) step();
        chk("t6_quiet0", 32'(falls[0] - fl0), 0);
        chk("t6_quiet1", 32'(falls[1] - fl1), 0);
        chk("t6_idle", 32'(busy), 0);

        chk("sb_empty0", 32'(q0.size()), 0);
        chk("sb_empty1", 32'(q1.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_emu_tx_multi.md
Name: ps2_emu_tx_multi

Overview:
Parametrised successor to the fixed keyboard/mouse PS/2 emulation transmitters. It provides CHANNELS independent PS/2 device-side serialisers, and each channel has its own FIFO of configurable depth. Compared with the fixed transmitters it adds:
- host-inhibit sensing, with abort and retransmit of the interrupted byte;
- FIFO full and sticky overflow reporting.

It sits between the SPI command decoder (producer of keyboard/mouse bytes, clk_sys domain) and the core's PS/2 controller inputs.

Parameters:
CHANNELS, 2, number of independent PS/2 channels (1..8); ch0 keyboard, ch1 mouse by convention
FIFO_BITS, 3, log2 of per-channel FIFO depth (1..6); depth = 2^FIFO_BITS
PS2DIV, 100, half-period of PS/2 clock in clk_sys cycles (>=2); PS/2 clock period = 2*PS2DIV cycles

Ports:
clk_sys  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
wr_data  in  8*CHANNELS  byte per channel, ch n at [8n+7:8n]
wr_strobe  in  CHANNELS  one-cycle write pulse per channel
ps2_clk_in  in  CHANNELS  sensed PS/2 clock line (host may hold low = inhibit)
overflow_clr  in  CHANNELS  clears sticky overflow of channel n
ps2_clk_out  out  CHANNELS  device clock drive, 1 = released
ps2_data_out  out  CHANNELS  device data drive, 1 = released
fifo_full  out  CHANNELS  channel FIFO holds depth bytes
fifo_overflow  out  CHANNELS  sticky: write dropped while full
busy  out  CHANNELS  channel in a frame or FIFO non-empty

Behaviour:
Reset (reset_n low, async):
- divider counter=0, clk_ps2=0;
- all FIFOs empty (pointers and count 0);
- all states IDLE;
- ps2_clk_out=all 1, ps2_data_out=all 1, fifo_full=0, fifo_overflow=0, busy=0.
- Reset mid-frame aborts immediately; lines are released.

Divider (shared by all channels):
- Counter runs 0..PS2DIV-1. At PS2DIV-1 it wraps and toggles clk_ps2.
- tick = one-cycle pulse on the clk_sys cycle in which clk_ps2 goes 0->1.

FIFO (per channel):
- Count-based, width FIFO_BITS+1. Write pointer and read pointer wrap modulo depth.
- A write is accepted when count<depth, or when a pop occurs in the same cycle (count stays depth).
- Otherwise the write is dropped and fifo_overflow[n] is set.
- overflow_clr[n] clears the flag. If a clear and a new overflow occur in the same cycle, set wins.
- fifo_full = (count==depth).
- The head is popped only when a frame completes successfully (STOP done), never at frame start.

Channel FSM (advances only on tick):
- IDLE:
  - If FIFO non-empty and inhibit not seen: latch head byte into the shift register, parity=1, data=0 (start bit), go to DATA with bit index 0.
- DATA:
  - Drive shift[0], shift right, toggle parity if the bit is 1.
  - After bit 7, go to PARITY.
- PARITY: drive parity (odd parity over the 8 bits); go to STOP.
- STOP: drive 1; go to DONE.
- DONE: pop FIFO; data=1; go to IDLE.
- ps2_clk_out[n] = clk_ps2 OR (state==IDLE). The frame gives 11 low clock pulses: start, 8 data, parity, stop.

Inhibit:
- inhibit[n] = ps2_clk_in[n]==0 while ps2_clk_out[n]==1, sampled through a 2-flop synchroniser and evaluated on tick.
- In IDLE, inhibit blocks frame start.
- In any other state, inhibit aborts: state=IDLE, data=1, no pop. The same byte restarts from the start bit on the first tick after inhibit releases.
- An inhibit first seen at the DONE tick does not abort; the pop proceeds.

Simultaneous events:
- wr_strobe on the cycle of the DONE pop is legal. Count is unchanged; the new byte is stored.
- Channels are fully independent and may be mid-frame simultaneously, sharing tick.

busy[n] = (state!=IDLE) OR (count!=0).

Latency: a write into an empty idle FIFO drives the start bit at the next tick (at most 2*PS2DIV cycles later).

Test Plan:
1. PS2DIV=2, ch0 write 0x1C -> ps2_data_out[0] on successive ticks 0,0,0,1,1,1,0,0,0,0(parity),1(stop); 11 clock low pulses; busy drops after DONE; FIFO empty.
2. FIFO_BITS=2, write 5 bytes back-to-back to ch1 with the line inhibited -> fifo_full=1 after 4, fifo_overflow[1]=1 on 5th, bytes 1..4 are transmitted in order after release; overflow_clr[1] clears the flag.
3. Hold ps2_clk_in[0]=0 during data bit 4 of 0xA5 -> lines released within 1 tick, no pop; after release a full 0xA5 frame (parity 1) repeats, then the next byte follows.
4. Ch0 sends 0x12 while ch1 sends 0xFF concurrently -> both frames correct, ch1 parity bit=1, no cross-talk.
5. Full FIFO, wr_strobe coincident with the DONE pop -> the byte is accepted, no overflow, fifo_full stays 1.
6. Assert reset_n=0 mid-frame -> all outputs at reset values asynchronously; after release no frame starts until a new write.
